fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 9 +
 rtl/fetch_queue_if.sv | 30 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/fetch_queue.sv | 77 +++++++
 tb/tb_fetch_queue.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline package for the IF/ID/EXE stages: common widths and
// the architectural reset fetch address.
package fetch_queue_pkg;

  localparam int unsigned PIPE_ADDR_W = 32;
  localparam int unsigned PIPE_INST_W = 32;
  localparam logic [31:0] PIPE_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, redirect/stall controls from the
// pipeline and the head-of-queue view presented to decode.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int INST_W = PIPE_INST_W
) ();

  logic              freeze;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              valid_out;
  logic [INST_W-1:0] instruction_out;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_rdata,
    output imem_en, imem_addr, valid_out, instruction_out, pc_out
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_rdata,
    input  imem_en, imem_addr, valid_out, instruction_out, pc_out
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; the read port shows the head entry
// combinationally and reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Occupancy flags; pushes when full and pops when empty are ignored.
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    full_s    = (count_r == CNT_W'(DEPTH));
    push_ok_s = push && !full_s;
    pop_ok_s  = pop && !empty_s;
    if (empty_s) begin
      rdata = {WIDTH{1'b0}};
    end else begin
      rdata = mem_r[rd_ptr_r];
    end
  end

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= push_ok_s ? wr_ptr_r + PTR_W'(1'b1) : wr_ptr_r;
      rd_ptr_r <= pop_ok_s ? rd_ptr_r + PTR_W'(1'b1) : rd_ptr_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign count = count_r;
  assign empty = empty_s;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential imem reads while there is room
// for the response, buffers {instruction, fetch address + PC_STEP} entries.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = PIPE_ADDR_W,
  parameter int                INST_W   = PIPE_INST_W,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PIPE_RESET_PC),
  localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.master    bus,
  output logic [CNT_W-1:0] count
);

  logic [ADDR_W-1:0]        pc_r;
  logic                     inflight_r;
  logic [CNT_W-1:0]         fifo_count_s;
  logic                     fifo_empty_s;
  logic [INST_W+ADDR_W-1:0] fifo_rdata_s;
  logic [CNT_W:0]           occupancy_s;
  logic                     issue_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     valid_s;

  // Reserve a slot for the in-flight response so the FIFO can never overflow;
  // a same-cycle pop is deliberately not credited.
  always_comb begin
    occupancy_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r};
    issue_s     = !rst && !bus.branch_taken && (occupancy_s < (CNT_W + 1)'(DEPTH));
    push_s      = inflight_r && !rst && !bus.branch_taken;
    valid_s     = !rst && !fifo_empty_s;
    pop_s       = valid_s && !bus.freeze && !bus.branch_taken;
  end

  // Fetch PC and in-flight tracking; redirect discards the pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      inflight_r <= 1'b0;
    end else if (bus.branch_taken) begin
      pc_r       <= bus.branch_addr;
      inflight_r <= 1'b0;
    end else begin
      pc_r       <= issue_s ? pc_r + ADDR_W'(PC_STEP) : pc_r;
      inflight_r <= issue_s;
    end
  end

  // While a response is in flight pc_r already holds its address + PC_STEP.
  sync_fifo #(
    .WIDTH (INST_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.branch_taken),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({bus.imem_rdata, pc_r}),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  assign bus.imem_en   = issue_s;
  assign bus.imem_addr = pc_r;
  assign bus.valid_out = valid_s;
  assign {bus.instruction_out, bus.pc_out} =
      valid_s ? fifo_rdata_s : {(INST_W + ADDR_W){1'b0}};
  assign count = rst ? {CNT_W{1'b0}} : fifo_count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed timing scenarios plus randomized
// freeze/branch/reset traffic, scored against an ideal sequential-stream model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  logic [2:0] count2;

  fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus  ();
  fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus2 ();

  fetch_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .count(count)
  );

  fetch_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .count(count2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int issues = 0;

  // Model: after a reset/redirect to A the consumer must see A, A+4, A+8, ...
  logic [63:0] exp_q[$];
  logic [31:0] next_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'hE3A0_1001;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory with one cycle of read latency; garbage when idle.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_en  ? mem_word(bus.imem_addr)  : $urandom();
    bus2.imem_rdata <= bus2.imem_en ? mem_word(bus2.imem_addr) : $urandom();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    exp_q.delete();
    next_addr = a;
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({mem_word(next_addr), next_addr + 32'd4});
      next_addr = next_addr + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Must be called just after a rising edge; returns at the start of cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    redirect(32'h0000_0000);
    refill();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: invariants every cycle, and every pop scored against the model.
  always @(negedge clk) begin
    check("valid_vs_count", 64'(bus.valid_out), 64'(count != 3'd0));
    check("count_bound", 64'(count <= 3'(DEPTH)), 64'd1);
    if (!bus.valid_out)
      check("empty_head_zero", {bus.instruction_out, bus.pc_out}, 64'd0);
    if (count == 3'(DEPTH) || rst || bus.branch_taken)
      check("imem_en_blocked", 64'(bus.imem_en), 64'd0);
    if (bus.valid_out && !bus.freeze && !bus.branch_taken) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_entry: got %h with no expected entry", {bus.instruction_out, bus.pc_out});
      end else begin
        check("pop_entry", {bus.instruction_out, bus.pc_out}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    int unsigned r;
    rst = 1'b1;
    bus.freeze = 1'b0;  bus.branch_taken = 1'b0;  bus.branch_addr = 32'd0;
    bus2.freeze = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_addr = 32'd0;
    redirect(32'h0000_0000);
    refill();

    // Reset state and first fetch after release.
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_en", 64'(bus.imem_en), 64'd0);
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("c0_imem_en", 64'(bus.imem_en), 64'd1);
    check("c0_imem_addr", 64'(bus.imem_addr), 64'h0);
    check("wrap_addr0", 64'(bus2.imem_addr), 64'hFFFF_FFF8);
    tick(); refill();
    @(negedge clk);
    check("c1_no_bypass", 64'(bus.valid_out), 64'd0);
    check("wrap_addr1", 64'(bus2.imem_addr), 64'hFFFF_FFFC);
    tick(); refill();
    @(negedge clk);
    check("c2_valid", 64'(bus.valid_out), 64'd1);
    check("c2_inst", 64'(bus.instruction_out), 64'hE3A0_1001);
    check("c2_pc_out", 64'(bus.pc_out), 64'h4);
    check("wrap_addr2", 64'(bus2.imem_addr), 64'h0);
    check("wrap_pc_out0", 64'(bus2.pc_out), 64'hFFFF_FFFC);
    check("wrap_count", 64'(count2), 64'd1);
    tick(); refill();
    @(negedge clk);
    check("wrap_pc_out1", 64'(bus2.pc_out), 64'h0);
    check("wrap_inst1", 64'(bus2.instruction_out), 64'(mem_word(32'hFFFF_FFFC)));
    tick(); refill();
    @(negedge clk);
    check("wrap_pc_out2", 64'(bus2.pc_out), 64'h4);

    // Freeze from reset for 10 cycles: exactly DEPTH issues, then stall.
    tick();
    do_reset();
    bus.freeze = 1'b1;
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issues += int'(bus.imem_en);
    end
    check("freeze_count", 64'(count), 64'd4);
    check("freeze_issues", 64'(issues), 64'd4);
    check("freeze_imem_en", 64'(bus.imem_en), 64'd0);
    tick();
    bus.freeze = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); refill();
    end

    // One-cycle reset while count=2 with a response in flight.
    do_reset();
    bus.freeze = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("pre_rst_count", 64'(count), 64'd2);
    #1;
    rst = 1'b1;
    redirect(32'h0000_0000);
    refill();
    #1;
    check("mid_rst_imem_en", 64'(bus.imem_en), 64'd0);
    check("mid_rst_valid", 64'(bus.valid_out), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_valid", 64'(bus.valid_out), 64'd0);
    check("post_rst_imem_en", 64'(bus.imem_en), 64'd1);
    check("post_rst_addr", 64'(bus.imem_addr), 64'h0);

    // Branch (with freeze) while count=3 and a response is in flight.
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("pre_br_count", 64'(count), 64'd3);
    #1;
    bus.branch_taken = 1'b1;
    bus.branch_addr  = 32'h0000_0100;
    redirect(32'h0000_0100);
    refill();
    #1;
    check("br_imem_en", 64'(bus.imem_en), 64'd0);
    tick();
    bus.branch_taken = 1'b0;
    @(negedge clk);
    check("br_t1_count", 64'(count), 64'd0);
    check("br_t1_imem_en", 64'(bus.imem_en), 64'd1);
    check("br_t1_addr", 64'(bus.imem_addr), 64'h100);
    @(negedge clk);
    check("br_t2_valid", 64'(bus.valid_out), 64'd0);
    @(negedge clk);
    check("br_t3_valid", 64'(bus.valid_out), 64'd1);
    check("br_t3_pc_out", 64'(bus.pc_out), 64'h104);
    check("br_t3_inst", 64'(bus.instruction_out), 64'(mem_word(32'h0000_0100)));
    tick();
    bus.freeze = 1'b0;

    // Randomized traffic: freeze bursts, redirects and occasional resets.
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      r = $urandom_range(0, 199);
      bus.branch_taken = 1'b0;
      rst = 1'b0;
      if (r < 2) begin
        rst = 1'b1;
        redirect(32'h0000_0000);
      end else if (r < 12) begin
        a = $urandom() & 32'hFFFF_FFFC;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = a;
        redirect(a);
      end
      if ($urandom_range(0, 15) == 0) bus.freeze = !bus.freeze;
      refill();
    end
    tick();
    rst = 1'b0;
    bus.branch_taken = 1'b0;
    bus.freeze = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); refill();
    end
    check("liveness", 64'(pops > 300), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
